// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage access controller: load/store op codes,
// bus size codes, FSM state encodings and store-lane formatting helpers.
package mem_access_ctrl_pkg;

    typedef logic [7:0] alu_op_t;

    localparam alu_op_t OP_LB  = 8'h40;
    localparam alu_op_t OP_LBU = 8'h41;
    localparam alu_op_t OP_LH  = 8'h42;
    localparam alu_op_t OP_LHU = 8'h43;
    localparam alu_op_t OP_LW  = 8'h44;
    localparam alu_op_t OP_SB  = 8'h45;
    localparam alu_op_t OP_SH  = 8'h46;
    localparam alu_op_t OP_SW  = 8'h47;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    function automatic logic [1:0] op_size(input alu_op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    // Replicate the store source across every lane so the memory picks it by byte enable.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            SZ_BYTE: return {4{wd[7:0]}};
            SZ_HALF: return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// SRAM-like data bus between the MEM-stage controller (master) and data memory (slave).
interface mem_access_ctrl_if;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );

endinterface

// File: rtl/mem_load_ext.sv
// Load result formatting: picks the byte/half lane by address and sign- or zero-extends it.
module mem_load_ext
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  alu_op_t     i_op,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // NOTE: the default arm covers every op code, so o_data is always assigned and no latch forms.
    always_comb begin
        case (i_op)
            OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_data = {24'd0, w_byte};
            OP_LH:   o_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: alignment checks, bus handshake FSM,
// store formatting, registered load result and pipeline stall generation.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               stall_ext,
    input  logic               memenM,
    input  logic               MemWriteM,
    input  alu_op_t            ALUControlM,
    input  logic [31:0]        aluoutM,
    input  logic [31:0]        writedataM,
    input  logic               exc_pendingM,
    mem_access_ctrl_if.master  bus,
    output logic [31:0]        readdataM,
    output logic               adelM_mem,
    output logic               adesM,
    output logic [31:0]        bad_addr_mem,
    output logic               stall_mem
);

    logic [1:0]  r_state;
    logic [31:0] r_readdata;

    logic [1:0]  w_next_state;
    logic        w_capture;
    logic [1:0]  w_size;
    logic        w_err;
    logic        w_access;
    logic        w_advance;
    logic [31:0] w_load_data;

    assign w_size   = op_size(ALUControlM);
    assign w_err    = ((w_size == SZ_HALF) & aluoutM[0]) |
                      ((w_size == SZ_WORD) & (|aluoutM[1:0]));
    assign w_access = memenM & ~exc_pendingM & ~w_err & ~flush;

    assign adelM_mem    = memenM & w_err & ~MemWriteM;
    assign adesM        = memenM & w_err & MemWriteM;
    assign bad_addr_mem = aluoutM;

    // Gating with reset releases the bus and the pipeline in the same cycle reset is seen.
    assign bus.data_req   = ~reset & (r_state == ST_IDLE) & w_access;
    assign bus.data_wr    = MemWriteM;
    assign bus.data_size  = w_size;
    assign bus.data_addr  = aluoutM;
    assign bus.data_wdata = store_lanes(w_size, writedataM);

    assign stall_mem = ~reset & (((r_state == ST_IDLE) & w_access) |
                                 (r_state == ST_DATA) | (r_state == ST_DRAIN));
    assign w_advance = ~stall_mem & ~stall_ext;
    assign readdataM = r_readdata;

    mem_load_ext u_load_ext (
        .i_rdata   (bus.data_rdata),
        .i_addr_lo (aluoutM[1:0]),
        .i_op      (ALUControlM),
        .o_data    (w_load_data)
    );

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access && bus.data_addr_ok) begin
                    if (bus.data_data_ok) begin
                        w_next_state = ST_DONE;
                        w_capture    = 1'b1;
                    end else begin
                        w_next_state = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // A flushed access still owes the bus one response; DRAIN absorbs it.
                if (flush) begin
                    w_next_state = bus.data_data_ok ? ST_IDLE : ST_DRAIN;
                end else if (bus.data_data_ok) begin
                    w_next_state = ST_DONE;
                    w_capture    = 1'b1;
                end
            end
            ST_DONE: begin
                if (w_advance || flush) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                if (bus.data_data_ok) begin
                    w_next_state = ST_IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_readdata <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_capture && !MemWriteM) begin
                r_readdata <= w_load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl: handshake timing, load extension,
// store formatting, address errors, flush/drain, bus back-pressure and mid-access reset.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        stall_ext;
    logic        memenM;
    logic        MemWriteM;
    alu_op_t     ALUControlM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        exc_pendingM;
    logic [31:0] readdataM;
    logic        adelM_mem;
    logic        adesM;
    logic [31:0] bad_addr_mem;
    logic        stall_mem;

    int n_checks = 0;
    int n_errors = 0;

    mem_access_ctrl_if bus();

    mem_access_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .stall_ext    (stall_ext),
        .memenM       (memenM),
        .MemWriteM    (MemWriteM),
        .ALUControlM  (ALUControlM),
        .aluoutM      (aluoutM),
        .writedataM   (writedataM),
        .exc_pendingM (exc_pendingM),
        .bus          (bus),
        .readdataM    (readdataM),
        .adelM_mem    (adelM_mem),
        .adesM        (adesM),
        .bad_addr_mem (bad_addr_mem),
        .stall_mem    (stall_mem)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'd0;
    endtask

    task automatic set_op(input logic wr, input alu_op_t op, input logic [31:0] addr,
                          input logic [31:0] wd);
        memenM      = 1'b1;
        MemWriteM   = wr;
        ALUControlM = op;
        aluoutM     = addr;
        writedataM  = wd;
    endtask

    task automatic test_reset;
        set_op(1'b0, OP_LW, 32'h0000_0010, 32'd0);
        #1;
        n_checks++; if (bus.data_req !== 1'b0) begin n_errors++; $display("FAIL rst_req_in_reset: got %b exp 0", bus.data_req); end
        n_checks++; if (stall_mem !== 1'b0) begin n_errors++; $display("FAIL rst_stall_in_reset: got %b exp 0", stall_mem); end
        tick;
        memenM = 1'b0;
        reset  = 1'b0;
        #1;
        n_checks++; if (readdataM !== 32'd0) begin n_errors++; $display("FAIL rst_readdata: got %h exp 00000000", readdataM); end
        n_checks++; if (bus.data_req !== 1'b0) begin n_errors++; $display("FAIL rst_req: got %b exp 0", bus.data_req); end
        n_checks++; if (stall_mem !== 1'b0) begin n_errors++; $display("FAIL rst_stall: got %b exp 0", stall_mem); end
        tick;
    endtask

    task automatic test_lw_wait;
        set_op(1'b0, OP_LW, 32'h0000_0100, 32'd0);
        bus.data_addr_ok = 1'b1;
        #1;
        n_checks++; if (bus.data_req !== 1'b1) begin n_errors++; $display("FAIL lw_req_c0: got %b exp 1", bus.data_req); end
        n_checks++; if (stall_mem !== 1'b1) begin n_errors++; $display("FAIL lw_stall_c0: got %b exp 1", stall_mem); end
        n_checks++; if (bus.data_addr !== 32'h0000_0100) begin n_errors++; $display("FAIL lw_addr: got %h exp 00000100", bus.data_addr); end
        n_checks++; if (bus.data_size !== 2'd2 || bus.data_wr !== 1'b0) begin n_errors++; $display("FAIL lw_size_wr: got %0d/%b exp 2/0", bus.data_size, bus.data_wr); end
        tick;
        bus_idle;
        #1;
        n_checks++; if (stall_mem !== 1'b1 || bus.data_req !== 1'b0) begin n_errors++; $display("FAIL lw_c1 stall/req: got %b/%b exp 1/0", stall_mem, bus.data_req); end
        tick;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (stall_mem !== 1'b1) begin n_errors++; $display("FAIL lw_stall_c2: got %b exp 1", stall_mem); end
        tick;
        bus_idle;
        #1;
        n_checks++; if (stall_mem !== 1'b0 || bus.data_req !== 1'b0) begin n_errors++; $display("FAIL lw_done stall/req: got %b/%b exp 0/0", stall_mem, bus.data_req); end
        n_checks++; if (readdataM !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL lw_readdata: got %h exp deadbeef", readdataM); end
        tick;
        memenM = 1'b0;
    endtask

    task automatic test_load_ext;
        alu_op_t     ops [4] = '{OP_LB, OP_LBU, OP_LH, OP_LHU};
        logic [31:0] adr [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
        logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8011, 32'h0000_2233};
        for (int i = 0; i < 4; i++) begin
            set_op(1'b0, ops[i], adr[i], 32'd0);
            bus.data_addr_ok = 1'b1;
            bus.data_data_ok = 1'b1;
            bus.data_rdata   = 32'h8011_2233;
            #1;
            n_checks++; if (stall_mem !== 1'b1) begin n_errors++; $display("FAIL ext%0d_stall_req: got %b exp 1", i, stall_mem); end
            tick;
            bus_idle;
            #1;
            n_checks++; if (readdataM !== exp[i]) begin n_errors++; $display("FAIL ext%0d_readdata: got %h exp %h", i, readdataM, exp[i]); end
            n_checks++; if (stall_mem !== 1'b0) begin n_errors++; $display("FAIL ext%0d_done_stall: got %b exp 0", i, stall_mem); end
            tick;
        end
        memenM = 1'b0;
    endtask

    task automatic test_store_addr_err;
        set_op(1'b1, OP_SH, 32'h0000_0102, 32'h0000_ABCD);
        bus.data_addr_ok = 1'b1;
        bus.data_data_ok = 1'b1;
        #1;
        n_checks++; if (bus.data_size !== 2'd1) begin n_errors++; $display("FAIL sh_size: got %0d exp 1", bus.data_size); end
        n_checks++; if (bus.data_wdata !== 32'hABCD_ABCD) begin n_errors++; $display("FAIL sh_wdata: got %h exp abcdabcd", bus.data_wdata); end
        n_checks++; if (bus.data_wr !== 1'b1 || bus.data_req !== 1'b1) begin n_errors++; $display("FAIL sh_wr_req: got %b/%b exp 1/1", bus.data_wr, bus.data_req); end
        n_checks++; if (adesM !== 1'b0) begin n_errors++; $display("FAIL sh_ades: got %b exp 0", adesM); end
        tick;
        bus_idle;
        #1;
        n_checks++; if (readdataM !== 32'h0000_2233) begin n_errors++; $display("FAIL sh_no_capture: got %h exp 00002233", readdataM); end
        tick;
        set_op(1'b1, OP_SB, 32'h0000_0101, 32'h1234_56EF);
        #1;
        n_checks++; if (bus.data_wdata !== 32'hEFEF_EFEF || bus.data_size !== 2'd0) begin n_errors++; $display("FAIL sb_wdata_size: got %h/%0d exp efefefef/0", bus.data_wdata, bus.data_size); end
        set_op(1'b1, OP_SW, 32'h0000_0106, 32'h1111_2222);
        #1;
        n_checks++; if (adesM !== 1'b1 || adelM_mem !== 1'b0) begin n_errors++; $display("FAIL sw_ades/adel: got %b/%b exp 1/0", adesM, adelM_mem); end
        n_checks++; if (bad_addr_mem !== 32'h0000_0106) begin n_errors++; $display("FAIL sw_bad_addr: got %h exp 00000106", bad_addr_mem); end
        n_checks++; if (bus.data_req !== 1'b0 || stall_mem !== 1'b0) begin n_errors++; $display("FAIL sw_err_req/stall: got %b/%b exp 0/0", bus.data_req, stall_mem); end
        set_op(1'b0, OP_LH, 32'h0000_0101, 32'd0);
        #1;
        n_checks++; if (adelM_mem !== 1'b1 || adesM !== 1'b0 || bus.data_req !== 1'b0) begin n_errors++; $display("FAIL lh_adel/ades/req: got %b/%b/%b exp 1/0/0", adelM_mem, adesM, bus.data_req); end
        set_op(1'b0, OP_LW, 32'h0000_0108, 32'd0);
        exc_pendingM = 1'b1;
        #1;
        n_checks++; if (bus.data_req !== 1'b0 || stall_mem !== 1'b0 || adelM_mem !== 1'b0) begin n_errors++; $display("FAIL exc_pending req/stall/adel: got %b/%b/%b exp 0/0/0", bus.data_req, stall_mem, adelM_mem); end
        exc_pendingM = 1'b0;
        memenM       = 1'b0;
        tick;
    endtask

    task automatic test_flush_drain;
        set_op(1'b0, OP_LW, 32'h0000_0200, 32'd0);
        bus.data_addr_ok = 1'b1;
        tick;
        bus_idle;
        flush = 1'b1;
        #1;
        n_checks++; if (stall_mem !== 1'b1 || bus.data_req !== 1'b0) begin n_errors++; $display("FAIL fl_data stall/req: got %b/%b exp 1/0", stall_mem, bus.data_req); end
        tick;
        flush = 1'b0;
        set_op(1'b0, OP_LW, 32'h0000_0204, 32'd0);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (stall_mem !== 1'b1 || bus.data_req !== 1'b0) begin n_errors++; $display("FAIL drain%0d stall/req: got %b/%b exp 1/0", i, stall_mem, bus.data_req); end
            tick;
        end
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h1234_5678;
        #1;
        n_checks++; if (stall_mem !== 1'b1 || bus.data_req !== 1'b0) begin n_errors++; $display("FAIL drain_ok stall/req: got %b/%b exp 1/0", stall_mem, bus.data_req); end
        tick;
        bus_idle;
        #1;
        n_checks++; if (readdataM !== 32'h0000_2233) begin n_errors++; $display("FAIL drain_readdata: got %h exp 00002233", readdataM); end
        n_checks++; if (bus.data_req !== 1'b1 || bus.data_addr !== 32'h0000_0204) begin n_errors++; $display("FAIL post_drain_req/addr: got %b/%h exp 1/00000204", bus.data_req, bus.data_addr); end
        bus.data_addr_ok = 1'b1;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'hCAFE_F00D;
        tick;
        bus_idle;
        #1;
        n_checks++; if (readdataM !== 32'hCAFE_F00D || stall_mem !== 1'b0) begin n_errors++; $display("FAIL post_drain_done rd/stall: got %h/%b exp cafef00d/0", readdataM, stall_mem); end
        tick;
        set_op(1'b0, OP_LW, 32'h0000_0300, 32'd0);
        bus.data_addr_ok = 1'b1;
        tick;
        bus_idle;
        flush            = 1'b1;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h5555_5555;
        tick;
        bus_idle;
        flush  = 1'b0;
        memenM = 1'b0;
        #1;
        n_checks++; if (stall_mem !== 1'b0 || readdataM !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL flush_ok_discard stall/rd: got %b/%h exp 0/cafef00d", stall_mem, readdataM); end
        tick;
    endtask

    task automatic test_back_to_back;
        set_op(1'b1, OP_SW, 32'h0000_0300, 32'h1122_3344);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (bus.data_req !== 1'b1 || stall_mem !== 1'b1) begin n_errors++; $display("FAIL hold%0d req/stall: got %b/%b exp 1/1", i, bus.data_req, stall_mem); end
            n_checks++; if (bus.data_addr !== 32'h300 || bus.data_size !== 2'd2 || bus.data_wdata !== 32'h1122_3344) begin n_errors++; $display("FAIL hold%0d addr/size/wdata: got %h/%0d/%h exp 00000300/2/11223344", i, bus.data_addr, bus.data_size, bus.data_wdata); end
            tick;
        end
        bus.data_addr_ok = 1'b1;
        tick;
        bus_idle;
        bus.data_data_ok = 1'b1;
        #1;
        n_checks++; if (stall_mem !== 1'b1 || bus.data_req !== 1'b0) begin n_errors++; $display("FAIL sw_data stall/req: got %b/%b exp 1/0", stall_mem, bus.data_req); end
        tick;
        bus_idle;
        stall_ext = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) stall_ext = 1'b0;
            #1;
            n_checks++; if (bus.data_req !== 1'b0 || stall_mem !== 1'b0) begin n_errors++; $display("FAIL done_hold%0d req/stall: got %b/%b exp 0/0", i, bus.data_req, stall_mem); end
            tick;
        end
        #1;
        n_checks++; if (bus.data_req !== 1'b1) begin n_errors++; $display("FAIL next_instr_req: got %b exp 1", bus.data_req); end
        n_checks++; if (readdataM !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL sw_no_capture: got %h exp cafef00d", readdataM); end
        memenM = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        set_op(1'b0, OP_LW, 32'h0000_0400, 32'd0);
        bus.data_addr_ok = 1'b1;
        tick;
        bus_idle;
        memenM = 1'b0;
        reset  = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        n_checks++; if (bus.data_req !== 1'b0 || stall_mem !== 1'b0) begin n_errors++; $display("FAIL rst_mid req/stall: got %b/%b exp 0/0", bus.data_req, stall_mem); end
        n_checks++; if (readdataM !== 32'd0) begin n_errors++; $display("FAIL rst_mid_readdata: got %h exp 00000000", readdataM); end
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h9999_9999;
        tick;
        bus_idle;
        #1;
        n_checks++; if (readdataM !== 32'd0 || stall_mem !== 1'b0) begin n_errors++; $display("FAIL rst_late_resp rd/stall: got %h/%b exp 00000000/0", readdataM, stall_mem); end
        tick;
    endtask

    initial begin
        reset        = 1'b1;
        flush        = 1'b0;
        stall_ext    = 1'b0;
        memenM       = 1'b0;
        MemWriteM    = 1'b0;
        ALUControlM  = OP_LW;
        aluoutM      = 32'd0;
        writedataM   = 32'd0;
        exc_pendingM = 1'b0;
        bus_idle;
        tick;
        test_reset;
        test_lw_wait;
        test_load_ext;
        test_store_addr_err;
        test_flush_drain;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
